// File: rtl/fifo_umbrales_if.sv
// fifo_umbrales_if: request, threshold-config and status bundle for one lane FIFO
interface fifo_umbrales_if #(parameter int DATA_WIDTH = 10);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic                  cfg_load;
    logic [2:0]            bajo;
    logic [2:0]            alto;
    logic [3:0]            count;
    logic                  empty;
    logic                  almost_empty;
    logic                  almost_full;
    logic                  full;
    logic                  error;
    modport master (
        output push, data_in, pop, cfg_load, bajo, alto,
        input  data_out, valid_out, count, empty, almost_empty, almost_full, full, error
    );
    modport slave (
        input  push, data_in, pop, cfg_load, bajo, alto,
        output data_out, valid_out, count, empty, almost_empty, almost_full, full, error
    );
endinterface

// File: rtl/fifo_umbrales.sv
// fifo_umbrales: 8-entry FIFO with programmable low/high occupancy thresholds.
// FIFO_ERR_STICKY_EN makes error sticky until reset; otherwise it pulses one cycle.
module fifo_umbrales #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8
) (
    input  logic           clk,
    input  logic           reset,
    fifo_umbrales_if.slave bus
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [2:0]            wr_ptr, rd_ptr;
    logic [3:0]            cnt, cnt_nxt;
    logic [2:0]            bajo_reg, alto_reg;
    logic [DATA_WIDTH-1:0] dout;
    logic                  vout, err;
    logic                  is_full, is_empty, do_pop, do_push, err_ev;

    assign is_empty = cnt == 4'd0;
    assign is_full  = cnt == 4'(DEPTH);
    // A full FIFO still takes a push when a pop frees a slot on the same edge
    assign do_pop   = bus.pop && !is_empty;
    assign do_push  = bus.push && (!is_full || do_pop);
    assign err_ev   = (bus.pop && is_empty) || (bus.push && is_full && !do_pop);

    always_comb begin
        cnt_nxt = cnt + {3'b0, do_push} - {3'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= 3'd0;
            rd_ptr   <= 3'd0;
            cnt      <= 4'd0;
            dout     <= '0;
            vout     <= 1'b0;
            err      <= 1'b0;
            bajo_reg <= 3'd1;
            alto_reg <= 3'd6;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 3'd1;
            if (do_pop) begin
                rd_ptr <= rd_ptr + 3'd1;
                dout   <= mem[rd_ptr];
            end
            vout <= do_pop;
            cnt  <= cnt_nxt;
            if (bus.cfg_load) begin
                bajo_reg <= bus.bajo;
                alto_reg <= bus.alto;
            end
`ifdef FIFO_ERR_STICKY_EN
            err <= err | err_ev;
`else
            err <= err_ev;
`endif
        end
    end

    assign bus.data_out     = dout;
    assign bus.valid_out    = vout;
    assign bus.count        = cnt;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = cnt <= {1'b0, bajo_reg};
    assign bus.almost_full  = cnt >= {1'b0, alto_reg};
    assign bus.error        = err;
endmodule

// File: tb/tb_fifo_umbrales.sv
// tb_fifo_umbrales: randomized and directed stimulus against a queue-based reference model
module tb_fifo_umbrales;
`ifdef FIFO_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit   armed = 1'b0;

    logic [9:0] model_q[$];
    logic [9:0] exp_q[$];
    int         mb = 1, ma = 6;
    bit         exp_err = 1'b0, exp_valid = 1'b0;

    fifo_umbrales_if #(.DATA_WIDTH(10)) bus ();
    fifo_umbrales dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: compares status against the model and scores every presented word
    always @(negedge clk) begin
        if (armed) begin
            chk("count", int'(bus.count), model_q.size());
            chk("empty", int'(bus.empty), int'(model_q.size() == 0));
            chk("full", int'(bus.full), int'(model_q.size() == 8));
            chk("almost_empty", int'(bus.almost_empty), int'(model_q.size() <= mb));
            chk("almost_full", int'(bus.almost_full), int'(model_q.size() >= ma));
            chk("error", int'(bus.error), int'(exp_err));
            chk("valid_out", int'(bus.valid_out), int'(exp_valid));
            if (bus.valid_out) begin
                if (exp_q.size() == 0) chk("unexpected_word", int'(bus.data_out), -1);
                else chk("data_out", int'(bus.data_out), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(bit ps, logic [9:0] d, bit pp, bit cl = 1'b0, logic [2:0] b = 3'd0, logic [2:0] a = 3'd0);
        int  n;
        bit  dpop, dpush, ev;
        bus.push = ps; bus.data_in = d; bus.pop = pp;
        bus.cfg_load = cl; bus.bajo = b; bus.alto = a;
        @(posedge clk);
        n     = model_q.size();
        dpop  = pp && n > 0;
        dpush = ps && (n < 8 || dpop);
        ev    = (pp && n == 0) || (ps && n == 8 && !dpop);
        exp_valid = dpop;
        if (dpop) exp_q.push_back(model_q.pop_front());
        if (dpush) model_q.push_back(d);
        if (cl) begin mb = int'(b); ma = int'(a); end
        exp_err = STICKY ? (exp_err | ev) : ev;
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.push = 1'b1; bus.pop = 1'b1; bus.cfg_load = 1'b1;
        bus.data_in = 10'h2AA; bus.bajo = 3'd5; bus.alto = 3'd3;
        @(posedge clk);
        model_q.delete(); exp_q.delete();
        mb = 1; ma = 6; exp_err = 1'b0; exp_valid = 1'b0;
        #1;
        reset = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.cfg_load = 1'b0;
        armed = 1'b1;
    endtask

    initial begin
        bus.push = 1'b0; bus.pop = 1'b0; bus.cfg_load = 1'b0;
        bus.data_in = '0; bus.bajo = '0; bus.alto = '0;
        do_reset();
        step(0, 0, 0);
        for (int i = 1; i <= 8; i++) step(1, 10'(i), 0);
        step(1, 10'h3FF, 1);
        step(1, 10'h155, 0);
        step(0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        do_reset();
        step(1, 10'h0AA, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(1, 10'h011, 0);
        step(1, 10'h022, 0);
        step(0, 0, 0, 1, 3'd0, 3'd2);
        step(0, 0, 0);
        step(1, 10'h033, 1, 1, 3'd7, 3'd0);
        step(0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 10'(16 + i), 0);
        for (int i = 3; i < 12; i++) step(1, 10'(16 + i), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1);
        step(0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else if ($urandom_range(0, 19) == 0)
                step(1'($urandom), 10'($urandom), 1'($urandom), 1'b1,
                     3'($urandom), 3'($urandom));
            else if (i % 100 < 50)
                step($urandom_range(0, 3) != 0, 10'($urandom), $urandom_range(0, 3) == 0);
            else
                step($urandom_range(0, 3) == 0, 10'($urandom), $urandom_range(0, 3) != 0);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
